quadencoderz_multi: RTL and testbench

//  Quadrature encoder counter with index (Z) handling and a selectable decode mode.

---
 rtl/quadencoderz_multi_if.sv | 17 +
 rtl/quadencoderz_multi.sv | 72 +++++++
 tb/tb_quadencoderz_multi.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/quadencoderz_multi_if.sv
// quadencoderz_multi_if: encoder pins, index handshake and counter status bundle
interface quadencoderz_multi_if #(
    parameter int WIDTH = 32,
    parameter int ERR_WIDTH = 8
);
    logic a, b, z, indexenable, indexout, index_seen;
    logic [WIDTH-1:0] position, index_position;
    logic [ERR_WIDTH-1:0] err_count;
    modport master (
        output a, b, z, indexenable,
        input indexout, position, index_position, index_seen, err_count
    );
    modport slave (
        input a, b, z, indexenable,
        output indexout, position, index_position, index_seen, err_count
    );
endinterface

// File: rtl/quadencoderz_multi.sv
// quadencoderz_multi: filtered quadrature counter with armed index reset and illegal-edge counter
module quadencoderz_multi #(
    parameter int WIDTH = 32,
    parameter int QUAD_MODE = 2,
    parameter int FILTER_LEN = 3,
    parameter int Z_INVERT = 0,
    parameter int ERR_WIDTH = 8
) (
    input logic clk,
    input logic rst_n,
    quadencoderz_multi_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ARMED, DONE} state_t;
    state_t state, state_nx;
    logic [2:0] s1, s2, filt, prev;
    logic [3:0] cnt [3];
    logic [1:0] chg;
    logic illegal, fwd, step, z_rise, fire;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
            filt <= '0;
            prev <= '0;
            for (int k = 0; k < 3; k++) cnt[k] <= '0;
        end else begin
            s1 <= {bus.a, bus.b, bus.z ^ 1'(Z_INVERT)};
            s2 <= s1;
            prev <= filt;
            for (int k = 0; k < 3; k++) begin
                if (s2[k] == filt[k]) cnt[k] <= '0;
                else if (cnt[k] == 4'(FILTER_LEN - 1)) begin
                    filt[k] <= s2[k];
                    cnt[k] <= '0;
                end else cnt[k] <= cnt[k] + 4'd1;
            end
        end
    end
    // bit 2 = A, bit 1 = B; forward steps always leave new A != old B
    assign chg = filt[2:1] ^ prev[2:1];
    assign illegal = &chg;
    assign fwd = filt[2] ^ prev[1];
    assign step = !illegal && (QUAD_MODE == 2 ? |chg : QUAD_MODE == 1 ? chg[1] : chg[1] && filt[2]);
    assign z_rise = filt[0] && !prev[0];
    always_ff @(posedge clk) state <= !rst_n ? IDLE : state_nx;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: state_nx = bus.indexenable ? ARMED : IDLE;
            ARMED: state_nx = !bus.indexenable ? IDLE : z_rise ? DONE : ARMED;
            DONE: state_nx = bus.indexenable ? DONE : IDLE;
            default: state_nx = IDLE;
        endcase
        bus.indexout = state == ARMED;
        fire = state == ARMED && bus.indexenable && z_rise;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.position <= '0;
            bus.index_position <= '0;
            bus.err_count <= '0;
            bus.index_seen <= 1'b0;
        end else begin
            bus.index_seen <= fire;
            if (fire) begin
                bus.index_position <= bus.position;
                bus.position <= '0;
            end else if (step) bus.position <= bus.position + (fwd ? WIDTH'(1) : {WIDTH{1'b1}});
            if (illegal && !(&bus.err_count)) bus.err_count <= bus.err_count + ERR_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_quadencoderz_multi.sv
// tb_quadencoderz_multi: x4/x2/x1 encoders on shared pins checked against a behavioural scoreboard
module tb_quadencoderz_multi;
    logic clk = 0, rst_n = 0, a = 0, b = 0, z = 0, ie = 0;
    always #5 clk = ~clk;
    quadencoderz_multi_if #(.WIDTH(32), .ERR_WIDTH(8)) i4 ();
    quadencoderz_multi_if #(.WIDTH(32), .ERR_WIDTH(8)) i2 ();
    quadencoderz_multi_if #(.WIDTH(4), .ERR_WIDTH(2)) i1 ();
    assign {i4.a, i4.b, i4.z, i4.indexenable} = {a, b, z, ie};
    assign {i2.a, i2.b, i2.z, i2.indexenable} = {a, b, z, ie};
    assign {i1.a, i1.b, i1.z, i1.indexenable} = {a, b, ~z, ie};
    quadencoderz_multi #(.WIDTH(32), .QUAD_MODE(2), .FILTER_LEN(3), .Z_INVERT(0), .ERR_WIDTH(8))
        d4 (.clk(clk), .rst_n(rst_n), .bus(i4.slave));
    quadencoderz_multi #(.WIDTH(32), .QUAD_MODE(1), .FILTER_LEN(3), .Z_INVERT(0), .ERR_WIDTH(8))
        d2 (.clk(clk), .rst_n(rst_n), .bus(i2.slave));
    quadencoderz_multi #(.WIDTH(4), .QUAD_MODE(0), .FILTER_LEN(3), .Z_INVERT(1), .ERR_WIDTH(2))
        d1 (.clk(clk), .rst_n(rst_n), .bus(i1.slave));
    logic [31:0] pos [3], ipos [3], err [3], iout [3];
    assign pos[0] = i4.position;
    assign pos[1] = i2.position;
    assign pos[2] = {28'b0, i1.position};
    assign ipos[0] = i4.index_position;
    assign ipos[1] = i2.index_position;
    assign ipos[2] = {28'b0, i1.index_position};
    assign err[0] = {24'b0, i4.err_count};
    assign err[1] = {24'b0, i2.err_count};
    assign err[2] = {30'b0, i1.err_count};
    assign iout[0] = {31'b0, i4.indexout};
    assign iout[1] = {31'b0, i2.indexout};
    assign iout[2] = {31'b0, i1.indexout};
    int seen [3] = '{0, 0, 0};
    always @(posedge clk) begin
        if (i4.index_seen) seen[0]++;
        if (i2.index_seen) seen[1]++;
        if (i1.index_seen) seen[2]++;
    end
    typedef struct {
        string tag;
        int d;
        int k;
        logic [31:0] ex;
    } ent_t;
    ent_t sb [$];
    int checks = 0, fails = 0;
    logic [31:0] p [3] = '{0, 0, 0};
    logic [31:0] ip [3] = '{0, 0, 0};
    logic [31:0] e [3] = '{0, 0, 0};
    int exp_seen [3] = '{0, 0, 0};
    int st = 0;
    int qm [3] = '{2, 1, 0};
    logic [31:0] mk [3] = '{32'hffffffff, 32'hffffffff, 32'hf};
    logic [31:0] emax [3] = '{255, 255, 3};
    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] ex);
        checks++;
        assert (o === ex) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, ex);
        end
    endtask
    function automatic logic [31:0] obs(input int d, input int k);
        return k == 0 ? pos[d] : k == 1 ? ipos[d] : k == 2 ? err[d] : k == 3 ? iout[d] : 32'(seen[d]);
    endfunction
    task automatic push(input string tag);
        for (int d = 0; d < 3; d++) begin
            sb.push_back('{tag, d, 0, p[d] & mk[d]});
            sb.push_back('{tag, d, 1, ip[d] & mk[d]});
            sb.push_back('{tag, d, 2, e[d]});
            sb.push_back('{tag, d, 3, 32'(st == 1)});
            sb.push_back('{tag, d, 4, 32'(exp_seen[d])});
        end
    endtask
    task automatic drain();
        ent_t t;
        while (sb.size() > 0) begin
            t = sb.pop_front();
            chk($sformatf("%s/dut%0d/item%0d", t.tag, t.d, t.k), obs(t.d, t.k), t.ex);
        end
    endtask
    task automatic checkpoint(input string tag);
        push(tag);
        repeat (8) @(posedge clk);
        #1;
        drain();
    endtask
    function automatic int gi(input logic x, input logic y);
        return {x, y} == 2'b00 ? 0 : {x, y} == 2'b10 ? 1 : {x, y} == 2'b11 ? 2 : 3;
    endfunction
    task automatic drive(input logic na, input logic nb, input bit lat = 0);
        int dd;
        logic [31:0] old;
        bit c;
        dd = (gi(na, nb) - gi(a, b)) & 3;
        old = p[0];
        for (int k = 0; k < 3; k++) begin
            if (dd == 2) begin
                if (e[k] != emax[k]) e[k]++;
            end else if (dd != 0) begin
                c = qm[k] == 2 || (qm[k] == 1 && na != a) || (qm[k] == 0 && na && !a);
                if (c) p[k] = dd == 1 ? p[k] + 1 : p[k] - 1;
            end
        end
        a = na;
        b = nb;
        if (lat) begin
            repeat (5) @(posedge clk);
            #1;
            chk("latency_early", pos[0], old);
            @(posedge clk);
            #1;
            chk("latency_exact", pos[0], p[0]);
        end else begin
            repeat (6) @(posedge clk);
            #1;
        end
    endtask
    task automatic fwd_cycle();
        drive(1, 0); drive(1, 1); drive(0, 1); drive(0, 0);
    endtask
    task automatic rev_cycle();
        drive(0, 1); drive(1, 1); drive(1, 0); drive(0, 0);
    endtask
    task automatic zset(input logic v);
        if (v && !z && st == 1) begin
            for (int k = 0; k < 3; k++) begin
                ip[k] = p[k];
                p[k] = 0;
                exp_seen[k]++;
            end
            st = 2;
        end
        z = v;
        repeat (6) @(posedge clk);
        #1;
    endtask
    task automatic set_ie(input logic v);
        ie = v;
        if (!v) st = 0;
        else if (st == 0) st = 1;
        repeat (3) @(posedge clk);
        #1;
    endtask
    initial begin
        repeat (3) @(posedge clk);
        #1;
        push("reset");
        drain();
        rst_n = 1;
        repeat (2) @(posedge clk);
        #1;
        repeat (5) fwd_cycle();
        checkpoint("fwd5");
        repeat (3) rev_cycle();
        checkpoint("rev3");
        repeat (3) fwd_cycle();
        checkpoint("back20");
        set_ie(1);
        checkpoint("armed");
        fwd_cycle();
        zset(1);
        zset(0);
        checkpoint("index_taken");
        zset(1);
        zset(0);
        fwd_cycle();
        checkpoint("index_done");
        set_ie(0);
        zset(1);
        set_ie(1);
        checkpoint("z_high_arm");
        fwd_cycle();
        zset(0);
        zset(1);
        checkpoint("z_fresh_edge");
        zset(0);
        set_ie(0);
        set_ie(1);
        set_ie(0);
        zset(1);
        zset(0);
        checkpoint("disarmed");
        drive(1, 1); drive(0, 0); drive(1, 1);
        checkpoint("err3");
        drive(0, 0); drive(1, 1);
        checkpoint("err_sat");
        drive(0, 0);
        drive(1, 0, 1);
        b = 1;
        @(posedge clk);
        #1;
        b = 0;
        checkpoint("glitch");
        drive(1, 1); drive(0, 1); drive(0, 0);
        for (int n = 0; n < 16 && (p[2] & 32'hf) != 32'h7; n++) fwd_cycle();
        checkpoint("x1_max");
        drive(1, 0);
        chk("wrap_min", pos[2], 32'h8);
        checkpoint("x1_wrap");
        drive(1, 1); drive(0, 1); drive(0, 0);
        fwd_cycle();
        a = 1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 0;
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_pos%0d", d), pos[d], 0);
            chk($sformatf("rst_ipos%0d", d), ipos[d], 0);
            chk($sformatf("rst_err%0d", d), err[d], 0);
            chk($sformatf("rst_iout%0d", d), iout[d], 0);
        end
        chk("rst_seen", {31'b0, i4.index_seen}, 0);
        a = 0;
        for (int k = 0; k < 3; k++) begin
            p[k] = 0;
            ip[k] = 0;
            e[k] = 0;
        end
        st = 0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1;
        checkpoint("after_reset");
        drive(1, 0);
        checkpoint("fresh_count");
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
